// File: rtl/glonass_pkg.sv
// Shared constants for the GLONASS L1 C/A chain: ST ranging code definition
// and default nav-data framing.
package glonass_pkg;

  localparam int         ST_LEN          = 511;
  localparam int         ST_POLY_TAPS [2] = '{5, 9};
  localparam int         ST_OUT_TAP      = 7;
  localparam logic [9:1] ST_INIT         = 9'h1FF;

  localparam int EPOCHS_PER_BIT_DEF = 20;
  localparam int MEANDER_HALF_DEF   = 10;

  // One ST shift: feedback s5^s9 enters s1, everything moves up one place.
  function automatic logic [9:1] st_step(input logic [9:1] s);
    return {s[8:1], s[ST_POLY_TAPS[0]] ^ s[ST_POLY_TAPS[1]]};
  endfunction

endpackage

// File: rtl/chip_tick_detect.sv
// Brings an asynchronous rate clock into the clk domain and emits a registered
// one-cycle tick per rising edge.
module chip_tick_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic chip_clk_i,
  output logic tick_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q[0] <= chip_clk_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= sync_q[SYNC_STAGES-1];
      tick_q <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/glonass_ca_modulator.sv
// GLONASS L1 C/A baseband modulator: ST code generator with epoch/bit framing,
// 100 Hz meander and a one-deep nav-bit holding register.
module glonass_ca_modulator
  import glonass_pkg::*;
#(
  parameter int EPOCHS_PER_BIT = EPOCHS_PER_BIT_DEF,
  parameter int MEANDER_HALF   = MEANDER_HALF_DEF,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       chip_clk,
  input  logic       nav_bit,
  input  logic       nav_valid,
  output logic       nav_ready,
  output logic       code_chip,
  output logic       chip_out,
  output logic       chip_tick,
  output logic       epoch,
  output logic       bit_start,
  output logic       meander,
  output logic [4:0] epoch_cnt,
  output logic       data_underrun
);

  localparam logic [8:0] LAST_IDX   = 9'(ST_LEN - 1);
  localparam logic [4:0] LAST_EPOCH = 5'(EPOCHS_PER_BIT - 1);
  localparam logic [4:0] MEANDER_TH = 5'(MEANDER_HALF);

  logic       tick;
  logic       boundary;
  logic [9:1] s_q, s_d;
  logic [8:0] chip_idx_q, chip_idx_d;
  logic [4:0] ecnt_q, ecnt_d;
  logic       hold_q, hold_d, hold_full_q, hold_full_d;
  logic       active_q, active_d;
  logic       code_q, code_d, out_q, out_d, tick_out_q, tick_out_d;
  logic       epoch_q, epoch_d, bstart_q, bstart_d, meander_q, meander_d;
  logic       under_q, under_d;
  logic [4:0] ecnt_out_q, ecnt_out_d;

  chip_tick_detect #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .chip_clk_i (chip_clk),
    .tick_o     (tick)
  );

  assign boundary = tick && (chip_idx_q == '0) && (ecnt_q == '0);

  always_comb begin
    s_d         = s_q;
    chip_idx_d  = chip_idx_q;
    ecnt_d      = ecnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    code_d      = code_q;
    out_d       = out_q;
    meander_d   = meander_q;
    ecnt_out_d  = ecnt_out_q;
    tick_out_d  = 1'b0;
    epoch_d     = 1'b0;
    bstart_d    = 1'b0;
    under_d     = 1'b0;

    if (tick) begin
      s_d        = st_step(s_q);
      chip_idx_d = (chip_idx_q == LAST_IDX) ? 9'd0 : chip_idx_q + 9'd1;
      if (chip_idx_q == LAST_IDX)
        ecnt_d = (ecnt_q == LAST_EPOCH) ? 5'd0 : ecnt_q + 5'd1;

      // The boundary decision only sees the register state before this edge,
      // so a bit offered in the same cycle waits for the next boundary.
      if (boundary) begin
        bstart_d = 1'b1;
        if (hold_full_q) begin
          active_d    = hold_q;
          hold_full_d = 1'b0;
        end else begin
          active_d = 1'b0;
          under_d  = 1'b1;
        end
      end

      code_d     = s_q[ST_OUT_TAP];
      meander_d  = (ecnt_q >= MEANDER_TH);
      out_d      = s_q[ST_OUT_TAP] ^ active_d ^ meander_d;
      ecnt_out_d = ecnt_q;
      tick_out_d = 1'b1;
      epoch_d    = (chip_idx_q == '0);
    end

    // valid/ready: a bit transfers on any clk edge where nav_valid and
    // nav_ready are both high; nav_ready is low exactly while holding is full.
    if (nav_valid && !hold_full_q) begin
      hold_d      = nav_bit;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= ST_INIT;
      chip_idx_q  <= '0;
      ecnt_q      <= '0;
      hold_q      <= 1'b0;
      hold_full_q <= 1'b0;
      active_q    <= 1'b0;
      code_q      <= 1'b0;
      out_q       <= 1'b0;
      tick_out_q  <= 1'b0;
      epoch_q     <= 1'b0;
      bstart_q    <= 1'b0;
      meander_q   <= 1'b0;
      under_q     <= 1'b0;
      ecnt_out_q  <= '0;
    end else begin
      s_q         <= s_d;
      chip_idx_q  <= chip_idx_d;
      ecnt_q      <= ecnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      code_q      <= code_d;
      out_q       <= out_d;
      tick_out_q  <= tick_out_d;
      epoch_q     <= epoch_d;
      bstart_q    <= bstart_d;
      meander_q   <= meander_d;
      under_q     <= under_d;
      ecnt_out_q  <= ecnt_out_d;
    end
  end

  // A maximal-length ST register is back at all ones after every 511 shifts.
  st_period_check: assert property (@(posedge clk)
    (rst_n && tick && chip_idx_q == LAST_IDX) |-> (s_d == ST_INIT));

  assign nav_ready     = ~hold_full_q;
  assign code_chip     = code_q;
  assign chip_out      = out_q;
  assign chip_tick     = tick_out_q;
  assign epoch         = epoch_q;
  assign bit_start     = bstart_q;
  assign meander       = meander_q;
  assign epoch_cnt     = ecnt_out_q;
  assign data_underrun = under_q;

endmodule
